// File: rtl/absdiff_pkg.sv
// absdiff_pkg: shared encodings for the absolute-difference unit.
//   - state_e  : control FSM state encoding (2 bits)
//   - A_SEL_*  : select codes for the A operand mux (2 bits)
//   - B_SEL_*  : select codes for the B operand mux (1 bit)
package absdiff_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_SWAP = 2'd1,
        STATE_SUB  = 2'd2,
        STATE_DONE = 2'd3
    } state_e;

    localparam logic [1:0] A_SEL_IN  = 2'd0;  // external operand a
    localparam logic [1:0] A_SEL_B   = 2'd1;  // current B (swap)
    localparam logic [1:0] A_SEL_SUB = 2'd2;  // A - B

    localparam logic B_SEL_IN = 1'b0;         // external operand b
    localparam logic B_SEL_A  = 1'b1;         // current A (swap)

endpackage

// File: rtl/absdiff_dpath.sv
// absdiff_dpath: operand registers A/B with load enables, 2:1/3:1 operand
// muxes, unsigned less-than comparator and subtractor.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears A, B)
//   a_en, b_en            register load enables
//   a_sel, b_sel          operand mux selects (absdiff_pkg codes)
//   istream_a, istream_b  external operands
//   is_lt                 A < B, status back to control
//   res                   current A register value
module absdiff_dpath
    import absdiff_pkg::*;
#(
    parameter int nbits = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_en,
    input  logic             b_en,
    input  logic [1:0]       a_sel,
    input  logic             b_sel,
    input  logic [nbits-1:0] istream_a,
    input  logic [nbits-1:0] istream_b,
    output logic             is_lt,
    output logic [nbits-1:0] res
);

    logic [nbits-1:0] a_q, a_d;
    logic [nbits-1:0] b_q, b_d;
    logic [nbits-1:0] a_mux, b_mux, diff;

    assign is_lt = (a_q < b_q);
    // Only ever used after the swap step, so A >= B and this never wraps.
    assign diff  = a_q - b_q;
    assign res   = a_q;

    always_comb begin
        a_mux = a_q;
        case (a_sel)
            A_SEL_IN:  a_mux = istream_a;
            A_SEL_B:   a_mux = b_q;
            A_SEL_SUB: a_mux = diff;
            default:   a_mux = a_q;
        endcase
        b_mux = (b_sel == B_SEL_A) ? a_q : istream_b;
        a_d   = a_en ? a_mux : a_q;
        b_d   = b_en ? b_mux : b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

endmodule

// File: rtl/absdiff_unit.sv
// absdiff_unit: multi-cycle unsigned |a-b| with val/rdy streams.
// Sequence IDLE -> SWAP -> SUB -> DONE -> IDLE; outputs decoded from state.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   istream_val/rdy/a/b       operand pair input stream
//   ostream_val/rdy/res       result output stream
module absdiff_unit
    import absdiff_pkg::*;
#(
    parameter int nbits = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] istream_a,
    input  logic [nbits-1:0] istream_b,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] ostream_res
);

    state_e     state_q, state_d;
    logic       a_en, b_en, b_sel, is_lt;
    logic [1:0] a_sel;

    // Next state and control decode.
    always_comb begin
        state_d = state_q;
        a_en    = 1'b0;
        b_en    = 1'b0;
        a_sel   = A_SEL_IN;
        b_sel   = B_SEL_IN;
        case (state_q)
            STATE_IDLE: begin
                if (istream_val) begin
                    a_en    = 1'b1;
                    b_en    = 1'b1;
                    state_d = STATE_SWAP;
                end
            end
            STATE_SWAP: begin
                // Put the larger operand in A so the subtract cannot wrap.
                if (is_lt) begin
                    a_en  = 1'b1;
                    b_en  = 1'b1;
                    a_sel = A_SEL_B;
                    b_sel = B_SEL_A;
                end
                state_d = STATE_SUB;
            end
            STATE_SUB: begin
                a_en    = 1'b1;
                a_sel   = A_SEL_SUB;
                state_d = STATE_DONE;
            end
            STATE_DONE: begin
                if (ostream_rdy) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= STATE_IDLE;
        else     state_q <= state_d;
    end

    assign istream_rdy = (state_q == STATE_IDLE);
    assign ostream_val = (state_q == STATE_DONE);

    absdiff_dpath #(.nbits(nbits)) u_dpath (
        .clk       (clk),
        .rst       (rst),
        .a_en      (a_en),
        .b_en      (b_en),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .istream_a (istream_a),
        .istream_b (istream_b),
        .is_lt     (is_lt),
        .res       (ostream_res)
    );

endmodule

// File: tb/tb_absdiff_unit.sv
module tb_absdiff_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       istream_val = 1'b0;
    logic       istream_rdy;
    logic [3:0] istream_a = 4'd0;
    logic [3:0] istream_b = 4'd0;
    logic       ostream_val;
    logic       ostream_rdy = 1'b1;
    logic [3:0] ostream_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    absdiff_unit #(.nbits(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_a   (istream_a),
        .istream_b   (istream_b),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_res (ostream_res)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for istream_rdy, present the pair, follow it to DONE.
    // With junk=1, istream_val stays high and a/b change during SWAP/SUB.
    task automatic run_pair(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] exp, input bit junk);
        int n = 0;
        while (!istream_rdy && n < 20) begin
            step();
            n++;
        end
        chk("istream_rdy_wait", int'(istream_rdy), 1);
        istream_val = 1'b1;
        istream_a   = a;
        istream_b   = b;
        step();                               // accept edge T
        if (junk) begin
            istream_a = ~a;
            istream_b = a;
        end else begin
            istream_val = 1'b0;
        end
        chk("rdy_T+1", int'(istream_rdy), 0);
        chk("val_T+1", int'(ostream_val), 0);
        step();
        if (junk) begin
            istream_a = 4'd15;
            istream_b = 4'd0;
        end
        chk("rdy_T+2", int'(istream_rdy), 0);
        chk("val_T+2", int'(ostream_val), 0);
        step();
        istream_val = 1'b0;
        chk("val_T+3", int'(ostream_val), 1);
        chk("rdy_T+3", int'(istream_rdy), 0);
        chk("res_T+3", int'(ostream_res), int'(exp));
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{a: 4'd4,  b: 4'd9,  res: 4'd5};
        vecs[1] = '{a: 4'd9,  b: 4'd4,  res: 4'd5};
        vecs[2] = '{a: 4'd7,  b: 4'd7,  res: 4'd0};
        vecs[3] = '{a: 4'd0,  b: 4'd15, res: 4'd15};
        vecs[4] = '{a: 4'd15, b: 4'd0,  res: 4'd15};
        vecs[5] = '{a: 4'd1,  b: 4'd0,  res: 4'd1};
        vecs[6] = '{a: 4'd6,  b: 4'd13, res: 4'd7};

        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_rdy", int'(istream_rdy), 1);
        chk("reset_val", int'(ostream_val), 0);
        chk("reset_res", int'(ostream_res), 0);

        // Table, back-to-back, sink always ready
        ostream_rdy = 1'b1;
        foreach (vecs[i]) begin
            run_pair(vecs[i].a, vecs[i].b, vecs[i].res, 1'b0);
            step();
            chk("back_to_idle", int'(istream_rdy), 1);
        end

        // Backpressure: DONE holds while sink is not ready
        ostream_rdy = 1'b0;
        run_pair(4'd12, 4'd3, 4'd9, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_val", int'(ostream_val), 1);
            chk("bp_res", int'(ostream_res), 9);
            chk("bp_rdy", int'(istream_rdy), 0);
        end
        ostream_rdy = 1'b1;
        step();
        chk("bp_release_val", int'(ostream_val), 0);
        chk("bp_release_rdy", int'(istream_rdy), 1);

        // Inputs changing while busy are ignored
        run_pair(4'd4, 4'd9, 4'd5, 1'b1);
        step();

        // Reset in SUB aborts the operation
        istream_val = 1'b1;
        istream_a   = 4'd2;
        istream_b   = 4'd14;
        step();                               // accepted, now SWAP
        istream_val = 1'b0;
        step();                               // now SUB
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_val", int'(ostream_val), 0);
        chk("abort_rdy", int'(istream_rdy), 1);
        chk("abort_res", int'(ostream_res), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_val", int'(ostream_val), 0);
        end
        run_pair(4'd1, 4'd3, 4'd2, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
